// File: rtl/load_store_unit.sv
// Load/store unit: issues LW/LBU/SW/SB to data memory over a valid/ready
// request channel and returns zero-extended load data to writeback.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [1:0]            ex_op,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    input  logic [4:0]            ex_rd,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  misalign,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [3:0]            mem_req_wstrb,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  accept;
    logic                  drop;
    logic                  word_mis;
    logic                  in_req;
    logic                  is_store;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic [7:0]            rsp_byte;

    // op[0] selects byte access, op[1] selects store
    assign word_mis = ~ex_op[0] & (ex_addr[1:0] != 2'b00);
    assign in_req   = (state_q == REQ);
    assign is_store = op_q[1];
    assign rsp_byte = mem_rsp_rdata[{addr_q[1:0], 3'b000} +: 8];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and stall decode
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        accept  = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (word_mis) begin
                        drop = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_req_ready) begin
                    if (is_store) begin
                        stall   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rsp_valid) begin
                    stall   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the accepted op so request fields stay stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
        end else if (accept) begin
            op_q    <= ex_op;
            addr_q  <= ex_addr;
            wdata_q <= ex_wdata;
            rd_q    <= ex_rd;
        end
    end

    // Writeback and misalign pulses; wb_data/wb_rd hold between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= '0;
            misalign <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= drop;
            if (state_q == WAIT && mem_rsp_valid) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                if (op_q[0]) wb_data <= {{(DATA_WIDTH-8){1'b0}}, rsp_byte};
                else         wb_data <= mem_rsp_rdata;
            end
        end
    end

    // Request channel, driven only while a request is pending
    always_comb begin
        mem_req_valid = in_req;
        mem_req_we    = in_req & is_store;
        mem_req_addr  = '0;
        mem_req_wstrb = 4'b0000;
        mem_req_wdata = '0;
        if (in_req) begin
            mem_req_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            if (is_store) begin
                if (op_q[0]) begin
                    mem_req_wstrb = 4'b0001 << addr_q[1:0];
                    mem_req_wdata = {4{wdata_q[7:0]}};
                end else begin
                    mem_req_wstrb = 4'b1111;
                    mem_req_wdata = wdata_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random ops checked
// against a byte-addressed memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ex_valid(ex_valid),
        .ex_op(ex_op),
        .ex_addr(ex_addr),
        .ex_wdata(ex_wdata),
        .ex_rd(ex_rd),
        .stall(stall),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .misalign(misalign),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr),
        .mem_req_wstrb(mem_req_wstrb),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // One memory op, starting just after a rising edge, ending on one
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd,
                         input int rdy_dly, input int rsp_dly);
        bit          st;
        bit          mis;
        logic [31:0] waddr;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] word;
        logic [31:0] exp_wb;
        st    = (op >= 2);
        mis   = (op == 0 || op == 2) && (a % 4 != 0);
        waddr = a - (a % 4);
        strb  = 4'd0;
        wd    = 32'd0;
        if (op == 2) begin
            strb = 4'hF;
            wd   = d;
        end else if (op == 3) begin
            strb = 4'(1 << (a % 4));
            wd   = (d & 32'hFF) * 32'h01010101;
        end

        #1;
        ex_valid = 1; ex_op = op; ex_addr = a; ex_wdata = d; ex_rd = rd;
        mem_req_ready = 0; mem_rsp_valid = 0;
        @(negedge clk);
        chk("accept_stall", 32'(stall), mis ? 32'd0 : 32'd1);
        chk("accept_noreq", 32'(mem_req_valid), 32'd0);
        @(posedge clk);

        if (mis) begin
            #1 ex_valid = 0;
            @(negedge clk);
            chk("mis_pulse", 32'(misalign), 32'd1);
            chk("mis_noreq", 32'(mem_req_valid), 32'd0);
            chk("mis_nowb", 32'(wb_valid), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("mis_end", 32'(misalign), 32'd0);
            chk("mis_noreq2", 32'(mem_req_valid), 32'd0);
            @(posedge clk);
            return;
        end

        for (int k = 0; k <= rdy_dly; k++) begin
            #1;
            mem_req_ready = (k == rdy_dly);
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rsp_rdata = $urandom;
            @(negedge clk);
            chk("req_valid", 32'(mem_req_valid), 32'd1);
            chk("req_we", 32'(mem_req_we), 32'(st));
            chk("req_addr", mem_req_addr, waddr);
            chk("req_wstrb", 32'(mem_req_wstrb), 32'(strb));
            if (st) chk("req_wdata", mem_req_wdata, wd);
            chk("req_stall", 32'(stall), (st && k == rdy_dly) ? 32'd0 : 32'd1);
            chk("req_nowb", 32'(wb_valid), 32'd0);
            @(posedge clk);
        end

        if (st) begin
            word = rd_word(waddr);
            for (int i = 0; i < 4; i++)
                if (strb[i]) word[8*i +: 8] = wd[8*i +: 8];
            mem[waddr] = word;
            #1;
            ex_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
            @(negedge clk);
            chk("st_done_stall", 32'(stall), 32'd0);
            chk("st_done_noreq", 32'(mem_req_valid), 32'd0);
            chk("st_nowb", 32'(wb_valid), 32'd0);
            @(posedge clk);
            return;
        end

        word = rd_word(waddr);
        for (int k = 0; k <= rsp_dly; k++) begin
            #1;
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = (k == rsp_dly);
            mem_rsp_rdata = (k == rsp_dly) ? word : $urandom;
            @(negedge clk);
            chk("wait_noreq", 32'(mem_req_valid), 32'd0);
            chk("wait_stall", 32'(stall), (k == rsp_dly) ? 32'd0 : 32'd1);
            chk("wait_nowb", 32'(wb_valid), 32'd0);
            @(posedge clk);
        end

        exp_wb = (op == 0) ? word : ((word >> (8 * (a % 4))) & 32'hFF);
        #1;
        ex_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
        @(negedge clk);
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("wb_data", wb_data, exp_wb);
        chk("wb_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wb_pulse_end", 32'(wb_valid), 32'd0);
        chk("wb_data_hold", wb_data, exp_wb);
        chk("wb_rd_hold", 32'(wb_rd), 32'(rd));
        @(posedge clk);
    endtask

    initial begin
        rst_n = 0; ex_valid = 0; ex_op = 0; ex_addr = 0; ex_wdata = 0;
        ex_rd = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_req_fields",
            mem_req_addr | mem_req_wdata | 32'(mem_req_wstrb) | 32'(mem_req_we),
            32'd0);
        rst_n = 1;
        @(posedge clk);

        // Directed cases
        do_op(2'b10, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0);
        do_op(2'b11, 32'h103, 32'h000000A5, 5'd2, 0, 0);
        mem[32'h200] = 32'h11223344;
        do_op(2'b01, 32'h202, 32'h0, 5'd9, 0, 0);
        do_op(2'b00, 32'h100, 32'h0, 5'd12, 3, 2);
        do_op(2'b00, 32'h106, 32'h0, 5'd3, 0, 0);
        do_op(2'b10, 32'h10A, 32'h12345678, 5'd4, 0, 0);
        do_op(2'b01, 32'h103, 32'h0, 5'd31, 1, 0);

        // Random mix in a small window so stores and loads alias
        for (int n = 0; n < 60; n++) begin
            do_op(2'($urandom_range(0, 3)),
                  32'h100 + 32'($urandom_range(0, 31)),
                  $urandom, 5'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting for a load response
        #1;
        ex_valid = 1; ex_op = 2'b00; ex_addr = 32'h300; ex_rd = 5'd7;
        @(posedge clk);
        #1 mem_req_ready = 1;
        @(posedge clk);
        #1;
        mem_req_ready = 0; ex_valid = 0; rst_n = 0;
        @(negedge clk);
        chk("rstw_stall_before", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1; mem_rsp_valid = 1; mem_rsp_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_noreq", 32'(mem_req_valid), 32'd0);
        chk("rstw_wb_data", wb_data, 32'd0);
        chk("rstw_wb_rd", 32'(wb_rd), 32'd0);
        @(posedge clk);
        #1 mem_rsp_valid = 0;
        @(negedge clk);
        chk("rstw_nowb", 32'(wb_valid), 32'd0);
        chk("rstw_wb_data2", wb_data, 32'd0);
        chk("rstw_idle_stall", 32'(stall), 32'd0);
        @(posedge clk);

        // Unit still works after the abandoned load
        do_op(2'b00, 32'h100, 32'h0, 5'd5, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
